idli_uart_m: RTL and testbench
==============================

// Module: idli_uart_m
// PURPOSE
//   Full-duplex UART for the idli core, parametrised in baud divider, data width and FIFO depth.
//   Drives the top-level UART pins, which the core currently ties off.
//   Presents byte-level valid/ready streams to the core, with a FIFO in each direction.
//   Framing is fixed: 8N1-style, LSB first, no parity.
// PARAMETERS
//   CLKS_PER_BIT  16  gck cycles per serial bit; >=4, even
//   DATA_BITS     8   payload bits per frame; 5..9
//   STOP_BITS     1   TX stop bits; 1 or 2 (RX checks only the first)
//   FIFO_DEPTH    4   entries per TX/RX FIFO; power of two, >=2
// PORTS
//   i_uart_gck           in   1          core clock
//   i_uart_rst_n         in   1          sync active-low reset
//   i_uart_tx_data       in   DATA_BITS  byte to transmit
//   i_uart_tx_vld        in   1          tx_data valid
//   o_uart_tx_rdy        out  1          TX FIFO not full
//   o_uart_rx_data       out  DATA_BITS  head of RX FIFO
//   o_uart_rx_vld        out  1          RX FIFO not empty
//   i_uart_rx_rdy        in   1          consumer pops RX head
//   o_uart_rx_overflow   out  1          1-cycle pulse: received byte dropped, FIFO full
//   o_uart_rx_frame_err  out  1          1-cycle pulse: stop bit sampled low
//   i_uart_rx            in   1          serial in (asynchronous)
//   o_uart_tx            out  1          serial out, idle high
// BEHAVIOUR
// - Clock and reset
//   - One clock, i_uart_gck. Reset is synchronous and active-low.
//   - While i_uart_rst_n=0 at a posedge:
//     - o_uart_tx=1, o_uart_rx_vld=0, o_uart_tx_rdy=1.
//     - Both error pulses 0. FIFOs emptied. FSMs return to IDLE.
//     - A frame in flight is aborted; o_uart_tx is high from the next cycle.
// - FIFOs: pointers of log2(DEPTH)+1 bits, wrapping.
//   - Push on vld&&rdy; pop on vld&&rdy (RX) or FSM load (TX).
//   - Simultaneous push and pop is legal.
//   - o_uart_tx_rdy = !tx_full; no bypass when full.
// - TX FSM: IDLE -> START -> DATA -> STOP -> IDLE, or START if the FIFO is non-empty.
//   - IDLE: if the FIFO is non-empty, pop into the shift register and go to START.
//   - Latency: a byte accepted at edge N into an empty, idle unit drives the start bit (0) from edge N+1.
//   - Each bit holds CLKS_PER_BIT cycles; a down-counter reloads per bit.
//   - DATA shifts LSB first, DATA_BITS bits. STOP drives 1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - Back-to-back: the next start bit follows the last stop cycle with no idle gap.
//   - Frame length = (1+DATA_BITS+STOP_BITS)*CLKS_PER_BIT cycles.
//   - o_uart_tx is registered.
// - RX input conditioning: i_uart_rx passes through a 2-flop synchroniser, which resets to 1.
// - RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE: a falling edge (sync'd 1->0) goes to START.
//   - START: sample at CLKS_PER_BIT/2 cycles. If high, it is a glitch: back to IDLE, nothing flagged.
//   - DATA: sample every CLKS_PER_BIT cycles (mid-bit), DATA_BITS samples, LSB first.
//   - STOP: sample mid-bit, then:
//     - 0: frame_err pulse, byte discarded.
//     - 1 and FIFO full with no pop that cycle: overflow pulse, byte discarded.
//     - otherwise: push the byte.
//   - After STOP the FSM returns to IDLE at the mid-stop sample, so the next start edge is caught.
// - Counters and errors
//   - Counter width is $clog2(CLKS_PER_BIT*2).
//   - No arithmetic overflow is permitted: counters reload, never wrap freely.
//   - Error pulses are exactly one cycle and never coincide with a push.
// TESTING (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1, FIFO_DEPTH=4)
//   - Push 0xA5 at cycle 0:
//     - o_uart_tx = 0 for cycles 1-4.
//     - Then bits 1,0,1,0,0,1,0,1, 4 cycles each.
//     - Then 1 for 4 cycles; 40-cycle frame, then idle high.
//   - Hold tx_vld with 0x00..0x07:
//     - tx_rdy drops once 4 are queued.
//     - 8 frames emitted in order, back-to-back, no idle cycles between frames.
//   - Drive a serial frame for 0x3C on i_uart_rx -> rx_vld rises with rx_data=0x3C. A 1-cycle low glitch -> nothing.
//   - Frame with stop bit 0 -> one frame_err pulse, rx_vld stays 0; the following valid frame 0x55 is received.
//   - rx_rdy=0, send 5 frames 0x10..0x14:
//     - overflow pulses once, on the 5th.
//     - Popping then returns 0x10..0x13.
//   - Assert reset mid-TX-data and mid-RX-data:
//     - o_uart_tx=1 next cycle, rx_vld=0, tx_rdy=1.
//     - A subsequent 0x81 is sent and received correctly.

Source files
------------

// File: rtl/idli_uart_m.sv
// idli UART: full-duplex serial port, LSB-first framing without parity,
// with a FIFO and a byte-level valid/ready stream in each direction.
module idli_uart_m #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int STOP_BITS    = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                 i_uart_gck,
    input  logic                 i_uart_rst_n,
    input  logic [DATA_BITS-1:0] i_uart_tx_data,
    input  logic                 i_uart_tx_vld,
    output logic                 o_uart_tx_rdy,
    output logic [DATA_BITS-1:0] o_uart_rx_data,
    output logic                 o_uart_rx_vld,
    input  logic                 i_uart_rx_rdy,
    output logic                 o_uart_rx_overflow,
    output logic                 o_uart_rx_frame_err,
    input  logic                 i_uart_rx,
    output logic                 o_uart_tx
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT * 2);
    localparam int ADR_W = $clog2(FIFO_DEPTH);
    localparam int PTR_W = ADR_W + 1;
    localparam int IDX_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(CLKS_PER_BIT * STOP_BITS - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     tx_wr;
    logic [PTR_W-1:0]     tx_rd;
    logic                 tx_full;
    logic                 tx_empty;
    logic                 tx_push;
    logic                 tx_pop;

    assign tx_empty = tx_wr == tx_rd;
    assign tx_full  = (tx_wr[ADR_W] != tx_rd[ADR_W]) &&
                      (tx_wr[ADR_W-1:0] == tx_rd[ADR_W-1:0]);
    assign tx_push  = i_uart_tx_vld && !tx_full;
    assign o_uart_tx_rdy = !tx_full;

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
        end
    end

    always_ff @(posedge i_uart_gck) begin
        if (tx_push) tx_mem[tx_wr[ADR_W-1:0]] <= i_uart_tx_data;
    end

    state_t               tx_state;
    state_t               tx_state_nxt;
    logic [CNT_W-1:0]     tx_cnt;
    logic [CNT_W-1:0]     tx_cnt_nxt;
    logic [DATA_BITS-1:0] tx_shift;
    logic [DATA_BITS-1:0] tx_shift_nxt;
    logic [IDX_W-1:0]     tx_idx;
    logic [IDX_W-1:0]     tx_idx_nxt;
    logic                 tx_line;
    logic                 tx_line_nxt;
    logic                 tx_load;

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            tx_state <= ST_IDLE;
            tx_cnt   <= '0;
            tx_shift <= '0;
            tx_idx   <= '0;
            tx_line  <= 1'b1;
        end else begin
            tx_state <= tx_state_nxt;
            tx_cnt   <= tx_cnt_nxt;
            tx_shift <= tx_shift_nxt;
            tx_idx   <= tx_idx_nxt;
            tx_line  <= tx_line_nxt;
        end
    end

    // Line level is computed from the next state so the start bit
    // appears on the very edge that pops the FIFO.
    always_comb begin
        tx_state_nxt = tx_state;
        tx_cnt_nxt   = tx_cnt;
        tx_shift_nxt = tx_shift;
        tx_idx_nxt   = tx_idx;
        tx_line_nxt  = tx_line;
        tx_load      = 1'b0;
        unique case (tx_state)
            ST_IDLE: begin
                tx_line_nxt = 1'b1;
                if (!tx_empty) tx_load = 1'b1;
            end
            ST_START: begin
                if (tx_cnt == '0) begin
                    tx_state_nxt = ST_DATA;
                    tx_cnt_nxt   = BIT_LAST;
                    tx_line_nxt  = tx_shift[0];
                    tx_shift_nxt = tx_shift >> 1;
                    tx_idx_nxt   = '0;
                end else begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end
            end
            ST_DATA: begin
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end else if (tx_idx == IDX_LAST) begin
                    tx_state_nxt = ST_STOP;
                    tx_cnt_nxt   = STOP_LAST;
                    tx_line_nxt  = 1'b1;
                end else begin
                    tx_idx_nxt   = tx_idx + 1'b1;
                    tx_cnt_nxt   = BIT_LAST;
                    tx_line_nxt  = tx_shift[0];
                    tx_shift_nxt = tx_shift >> 1;
                end
            end
            ST_STOP: begin
                if (tx_cnt != '0) begin
                    tx_cnt_nxt = tx_cnt - 1'b1;
                end else if (!tx_empty) begin
                    tx_load = 1'b1;
                end else begin
                    tx_state_nxt = ST_IDLE;
                end
            end
        endcase
        if (tx_load) begin
            tx_state_nxt = ST_START;
            tx_cnt_nxt   = BIT_LAST;
            tx_shift_nxt = tx_mem[tx_rd[ADR_W-1:0]];
            tx_line_nxt  = 1'b0;
        end
    end

    assign tx_pop    = tx_load;
    assign o_uart_tx = tx_line;

    logic [1:0] rx_sync;
    logic       rx_prev;
    logic       rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            rx_sync <= 2'b11;
            rx_prev <= 1'b1;
        end else begin
            rx_sync <= {rx_sync[0], i_uart_rx};
            rx_prev <= rx_sync[1];
        end
    end

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     rx_wr;
    logic [PTR_W-1:0]     rx_rd;
    logic                 rx_full;
    logic                 rx_push;
    logic                 rx_pop;

    assign rx_full = (rx_wr[ADR_W] != rx_rd[ADR_W]) &&
                     (rx_wr[ADR_W-1:0] == rx_rd[ADR_W-1:0]);
    assign o_uart_rx_vld  = rx_wr != rx_rd;
    assign o_uart_rx_data = rx_mem[rx_rd[ADR_W-1:0]];
    assign rx_pop = o_uart_rx_vld && i_uart_rx_rdy;

    state_t               rx_state;
    state_t               rx_state_nxt;
    logic [CNT_W-1:0]     rx_cnt;
    logic [CNT_W-1:0]     rx_cnt_nxt;
    logic [DATA_BITS-1:0] rx_shift;
    logic [DATA_BITS-1:0] rx_shift_nxt;
    logic [IDX_W-1:0]     rx_idx;
    logic [IDX_W-1:0]     rx_idx_nxt;
    logic                 ovf_nxt;
    logic                 ferr_nxt;

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
        end
    end

    always_ff @(posedge i_uart_gck) begin
        if (rx_push) rx_mem[rx_wr[ADR_W-1:0]] <= rx_shift;
    end

    always_ff @(posedge i_uart_gck) begin
        if (!i_uart_rst_n) begin
            rx_state            <= ST_IDLE;
            rx_cnt              <= '0;
            rx_shift            <= '0;
            rx_idx              <= '0;
            o_uart_rx_overflow  <= 1'b0;
            o_uart_rx_frame_err <= 1'b0;
        end else begin
            rx_state            <= rx_state_nxt;
            rx_cnt              <= rx_cnt_nxt;
            rx_shift            <= rx_shift_nxt;
            rx_idx              <= rx_idx_nxt;
            o_uart_rx_overflow  <= ovf_nxt;
            o_uart_rx_frame_err <= ferr_nxt;
        end
    end

    // Leaving STOP at the mid-bit sample keeps half a bit of margin
    // to catch a start edge that immediately follows.
    always_comb begin
        rx_state_nxt = rx_state;
        rx_cnt_nxt   = rx_cnt;
        rx_shift_nxt = rx_shift;
        rx_idx_nxt   = rx_idx;
        rx_push      = 1'b0;
        ovf_nxt      = 1'b0;
        ferr_nxt     = 1'b0;
        unique case (rx_state)
            ST_IDLE: begin
                if (rx_prev && !rx_s) begin
                    rx_state_nxt = ST_START;
                    rx_cnt_nxt   = HALF_LAST;
                end
            end
            ST_START: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end else if (rx_s) begin
                    rx_state_nxt = ST_IDLE;
                end else begin
                    rx_state_nxt = ST_DATA;
                    rx_cnt_nxt   = BIT_LAST;
                    rx_idx_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end else begin
                    rx_shift_nxt = {rx_s, rx_shift[DATA_BITS-1:1]};
                    rx_cnt_nxt   = BIT_LAST;
                    if (rx_idx == IDX_LAST) rx_state_nxt = ST_STOP;
                    else                    rx_idx_nxt   = rx_idx + 1'b1;
                end
            end
            ST_STOP: begin
                if (rx_cnt != '0) begin
                    rx_cnt_nxt = rx_cnt - 1'b1;
                end else begin
                    rx_state_nxt = ST_IDLE;
                    if (!rx_s)                     ferr_nxt = 1'b1;
                    else if (rx_full && !rx_pop)   ovf_nxt  = 1'b1;
                    else                           rx_push  = 1'b1;
                end
            end
        endcase
    end
endmodule

// File: tb/tb_idli_uart_m.sv
// Directed bench for idli_uart_m at 4 clocks per bit, 8 data bits,
// one stop bit and 4-entry FIFOs.
`timescale 1ns/1ps
module tb_idli_uart_m;
    localparam int CPB = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] tx_data = '0;
    logic       tx_vld = 1'b0;
    logic       tx_rdy;
    logic [7:0] rx_data;
    logic       rx_vld;
    logic       rx_rdy = 1'b0;
    logic       overflow;
    logic       frame_err;
    logic       rx = 1'b1;
    logic       tx;

    idli_uart_m #(
        .CLKS_PER_BIT(CPB),
        .DATA_BITS(8),
        .STOP_BITS(1),
        .FIFO_DEPTH(4)
    ) dut (
        .i_uart_gck(clk),
        .i_uart_rst_n(rst_n),
        .i_uart_tx_data(tx_data),
        .i_uart_tx_vld(tx_vld),
        .o_uart_tx_rdy(tx_rdy),
        .o_uart_rx_data(rx_data),
        .o_uart_rx_vld(rx_vld),
        .i_uart_rx_rdy(rx_rdy),
        .o_uart_rx_overflow(overflow),
        .o_uart_rx_frame_err(frame_err),
        .i_uart_rx(rx),
        .o_uart_tx(tx)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    // Counting high cycles makes a stretched pulse show up as extra counts.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] frame_exp(input logic [7:0] d);
        logic [39:0] v;
        for (int j = 0; j < 40; j++) begin
            if (j / 4 == 0)      v[j] = 1'b0;
            else if (j / 4 == 9) v[j] = 1'b1;
            else                 v[j] = d[j/4-1];
        end
        return v;
    endfunction

    // Called at the negedge right after the push edge; sample j is cycle j+1.
    task automatic capture_tx(output logic [39:0] v);
        for (int j = 0; j < 40; j++) begin
            @(negedge clk);
            v[j] = tx;
        end
    endtask

    task automatic send_rx(input logic [7:0] d, input logic stop);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = d[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    task automatic pop_rx(input string tag, input logic [7:0] exp);
        check({tag, "_vld"}, rx_vld, 1'b1);
        check(tag, rx_data, exp);
        rx_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
    endtask

    logic [39:0] cap;
    logic [39:0] mon_v;
    int          sent;
    int          blk;
    logic        acc;
    int          fe0;
    int          ov0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_rx_vld", rx_vld, 1'b0);
        check("rst_tx_rdy", tx_rdy, 1'b1);
        check("rst_ovf", overflow, 1'b0);
        check("rst_ferr", frame_err, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        tx_data = 8'hA5;
        tx_vld  = 1'b1;
        @(negedge clk);
        tx_vld = 1'b0;
        check("a5_idle_at_push", tx, 1'b1);
        capture_tx(cap);
        check("a5_frame", cap, 40'hFF0F00F0F0);
        @(negedge clk);
        check("a5_idle_after", tx, 1'b1);
        repeat (4) @(negedge clk);

        sent = 0;
        blk  = -1;
        fork
            begin
                tx_vld  = 1'b1;
                tx_data = 8'h00;
                while (sent < 8) begin
                    acc = tx_rdy;
                    if (!acc && blk < 0) blk = sent;
                    @(negedge clk);
                    if (acc) begin
                        sent++;
                        tx_data = 8'(sent);
                    end
                end
                tx_vld = 1'b0;
            end
            begin
                @(negedge clk);
                for (int f = 0; f < 8; f++) begin
                    capture_tx(mon_v);
                    check($sformatf("seq_frame%0d", f), mon_v,
                          frame_exp(8'(f)));
                end
            end
        join
        check("seq_rdy_drop_at", 64'(blk), 64'd5);
        repeat (3) @(negedge clk);
        check("seq_idle_after", tx, 1'b1);
        check("seq_rdy_after", tx_rdy, 1'b1);

        send_rx(8'h3C, 1'b1);
        pop_rx("rx_3c", 8'h3C);
        check("rx_3c_empty", rx_vld, 1'b0);

        fe0 = fe_cnt;
        rx  = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        check("glitch_vld", rx_vld, 1'b0);
        check("glitch_ferr", 64'(fe_cnt - fe0), 64'd0);

        fe0 = fe_cnt;
        send_rx(8'hC3, 1'b0);
        check("ferr_pulses", 64'(fe_cnt - fe0), 64'd1);
        check("ferr_vld", rx_vld, 1'b0);
        send_rx(8'h55, 1'b1);
        pop_rx("rx_55", 8'h55);

        ov0 = ov_cnt;
        for (int i = 0; i < 4; i++) send_rx(8'(8'h10 + i), 1'b1);
        check("ovf_none_4", 64'(ov_cnt - ov0), 64'd0);
        send_rx(8'h14, 1'b1);
        check("ovf_once_5", 64'(ov_cnt - ov0), 64'd1);
        for (int i = 0; i < 4; i++)
            pop_rx($sformatf("ovf_pop%0d", i), 8'(8'h10 + i));
        check("ovf_empty", rx_vld, 1'b0);

        send_rx(8'h77, 1'b1);
        rx      = 1'b0;
        tx_data = 8'h00;
        tx_vld  = 1'b1;
        repeat (5) @(negedge clk);
        tx_vld = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_tx_low", tx, 1'b0);
        check("mid_tx_full", tx_rdy, 1'b0);
        check("mid_rx_vld", rx_vld, 1'b1);
        rst_n = 1'b0;
        rx    = 1'b1;
        @(negedge clk);
        check("rst2_tx", tx, 1'b1);
        check("rst2_rx_vld", rx_vld, 1'b0);
        check("rst2_tx_rdy", tx_rdy, 1'b1);
        rst_n = 1'b1;
        fe0 = fe_cnt;
        repeat (50) @(negedge clk);
        check("rst2_tx_quiet", tx, 1'b1);
        check("rst2_rx_quiet", rx_vld, 1'b0);
        check("rst2_ferr", 64'(fe_cnt - fe0), 64'd0);

        tx_data = 8'h81;
        tx_vld  = 1'b1;
        @(negedge clk);
        tx_vld = 1'b0;
        capture_tx(cap);
        check("post_rst_tx81", cap, frame_exp(8'h81));
        send_rx(8'h81, 1'b1);
        pop_rx("post_rst_rx81", 8'h81);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
